// File: rtl/transceiver_frame_ctrl.sv
// Frame scheduler in front of transceiver_top: byte FIFO, MSB-first serializer, done/timeout wait, gap.
// Build option: define TXC_PREAMBLE_EN to send an 0xA5 preamble ahead of each data byte.
module transceiver_frame_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic [7:0]                        i_s_data,
    input  logic                              i_s_valid,
    output logic                              o_s_ready,
    output logic                              o_tx_en,
    output logic                              o_tx_bit,
    input  logic                              i_tx_active,
    input  logic                              i_tx_done,
    output logic                              o_busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_fifo_level,
    output logic [15:0]                       o_frame_cnt,
    output logic                              o_timeout_err,
    input  logic                              i_err_clr
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH+1);
    localparam int TW = $clog2(TIMEOUT);
    localparam int GW = $clog2(GAP_CYCLES) + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;
`ifdef TXC_PREAMBLE_EN
    localparam logic [2:0] S_PRE   = 3'd1;
    localparam logic [7:0] PREAMBLE = 8'hA5;
`endif

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;

    logic [2:0]    r_state;
    logic [7:0]    r_shreg;
    logic [2:0]    r_bitcnt;
    logic [TW-1:0] r_tocnt;
    logic [GW-1:0] r_gapcnt;
    logic          r_tx_en;
    logic          r_tx_bit;
    logic          r_busy;
    logic [15:0]   r_frame_cnt;
    logic          r_timeout_err;

    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_timeout;
    logic w_shift_bit;

    assign w_full      = (r_level == LW'(FIFO_DEPTH));
    assign w_push      = i_s_valid && !w_full;
    assign w_pop       = (r_state == S_IDLE) && (r_level != '0);
    assign w_timeout   = (r_state == S_WAIT) && !i_tx_done && (r_tocnt == TW'(TIMEOUT-1));
    assign w_shift_bit = r_shreg[3'd7 - r_bitcnt];

    assign o_s_ready     = !w_full;
    assign o_fifo_level  = r_level;
    assign o_tx_en       = r_tx_en;
    assign o_tx_bit      = r_tx_bit;
    assign o_busy        = r_busy;
    assign o_frame_cnt   = r_frame_cnt;
    assign o_timeout_err = r_timeout_err;

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_s_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Outputs are registered from the state held during the previous cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_shreg       <= '0;
            r_bitcnt      <= '0;
            r_tocnt       <= '0;
            r_gapcnt      <= '0;
            r_tx_en       <= 1'b0;
            r_tx_bit      <= 1'b0;
            r_busy        <= 1'b0;
            r_frame_cnt   <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_busy   <= (r_state != S_IDLE) || i_tx_active;
            r_tx_en  <= 1'b0;
            r_tx_bit <= 1'b0;
            if (w_timeout)      r_timeout_err <= 1'b1;
            else if (i_err_clr) r_timeout_err <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_shreg  <= r_mem[r_rd_ptr];
                        r_bitcnt <= '0;
`ifdef TXC_PREAMBLE_EN
                        r_state  <= S_PRE;
`else
                        r_state  <= S_SHIFT;
`endif
                    end
                end
`ifdef TXC_PREAMBLE_EN
                S_PRE: begin
                    r_tx_en  <= 1'b1;
                    r_tx_bit <= PREAMBLE[3'd7 - r_bitcnt];
                    r_bitcnt <= r_bitcnt + 3'd1;
                    if (r_bitcnt == 3'd7) r_state <= S_SHIFT;
                end
`endif
                S_SHIFT: begin
                    r_tx_en  <= 1'b1;
                    r_tx_bit <= w_shift_bit;
                    r_bitcnt <= r_bitcnt + 3'd1;
                    if (r_bitcnt == 3'd7) begin
                        r_state <= S_WAIT;
                        r_tocnt <= '0;
                    end
                end
                S_WAIT: begin
                    r_tx_en <= 1'b1;
                    r_tocnt <= r_tocnt + 1'b1;
                    // Done on the expiry cycle wins over the timeout.
                    if (i_tx_done) begin
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                        r_state     <= S_GAP;
                        r_gapcnt    <= '0;
                    end else if (w_timeout) begin
                        r_state  <= S_GAP;
                        r_gapcnt <= '0;
                    end
                end
                S_GAP: begin
                    r_gapcnt <= r_gapcnt + 1'b1;
                    if (r_gapcnt == GW'(GAP_CYCLES-1)) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_transceiver_frame_ctrl.sv
// Randomized bench for transceiver_frame_ctrl against a frame-timeline reference model.
module tb_transceiver_frame_ctrl;
    localparam int DEPTH = 4;
    localparam int GAP   = 4;
    localparam int TMO   = 64;
`ifdef TXC_PREAMBLE_EN
    localparam int NB = 16;
`else
    localparam int NB = 8;
`endif

    logic        clk = 1'b0;
    logic        rst, s_valid, tx_active, tx_done, err_clr;
    logic [7:0]  s_data;
    logic        s_ready, tx_en, tx_bit, busy, timeout_err;
    logic [2:0]  fifo_level;
    logic [15:0] frame_cnt;

    always #5 clk = ~clk;

    transceiver_frame_ctrl #(.FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP), .TIMEOUT(TMO)) dut (
        .i_clk(clk), .i_rst(rst), .i_s_data(s_data), .i_s_valid(s_valid), .o_s_ready(s_ready),
        .o_tx_en(tx_en), .o_tx_bit(tx_bit), .i_tx_active(tx_active), .i_tx_done(tx_done),
        .o_busy(busy), .o_fifo_level(fifo_level), .o_frame_cnt(frame_cnt),
        .o_timeout_err(timeout_err), .i_err_clr(err_clr)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Model: a frame is a timeline t = cycles since pop; t<NB shifts bit t, t>=NB waits.
    logic [7:0]  m_q[$];
    int          m_mode;      // 0 idle, 1 in frame, 2 gap
    int          m_t, m_gap;
    logic [15:0] m_word, m_cnt;
    logic        m_err, m_en, m_bit, m_busy, m_acc;

    task automatic step();
        logic to;
        to = 1'b0;
        m_acc = 1'b0;
        if (rst) begin
            m_q.delete();
            m_mode = 0; m_cnt = '0; m_err = 0; m_en = 0; m_bit = 0; m_busy = 0;
        end else begin
            m_en   = (m_mode == 1);
            m_bit  = (m_mode == 1 && m_t < NB) ? m_word[NB-1-m_t] : 1'b0;
            m_busy = (m_mode != 0) || tx_active;
            m_acc  = s_valid && (m_q.size() < DEPTH);
            case (m_mode)
                0: if (m_q.size() > 0) begin
                    m_word = (NB == 16) ? {8'hA5, m_q.pop_front()} : {8'h00, m_q.pop_front()};
                    m_mode = 1; m_t = 0;
                end
                1: if (m_t < NB) m_t++;
                   else if (tx_done) begin m_cnt = m_cnt + 16'd1; m_mode = 2; m_gap = GAP; end
                   else if (m_t - NB == TMO - 1) begin to = 1'b1; m_mode = 2; m_gap = GAP; end
                   else m_t++;
                default: if (m_gap == 1) m_mode = 0; else m_gap--;
            endcase
            if (to) m_err = 1'b1;
            else if (err_clr) m_err = 1'b0;
            if (m_acc) m_q.push_back(s_data);
        end
        @(posedge clk);
        #1;
        chk("tx_en", tx_en, m_en);
        chk("tx_bit", tx_bit, m_bit);
        chk("busy", busy, m_busy);
        chk("level", fifo_level, m_q.size());
        chk("s_ready", s_ready, m_q.size() < DEPTH);
        chk("frame_cnt", frame_cnt, m_cnt);
        chk("timeout_err", timeout_err, m_err);
    endtask

    function automatic logic at_expiry();
        return (m_mode == 1) && (m_t == NB + TMO - 1);
    endfunction

    initial begin
        logic [15:0] stream, exp_stream;
        int nbits, gapn, k, maxl, ok;
        logic saw_full;
        rst = 1; s_valid = 0; s_data = 0; tx_active = 0; tx_done = 0; err_clr = 0;
        m_q.delete(); m_mode = 0; m_t = 0; m_gap = 0; m_word = 0; m_cnt = 0; m_err = 0;
        repeat (2) step();
        rst = 0;
        step();

        // Reset mid-shift
        s_valid = 1; s_data = 8'h5A; step(); s_valid = 0;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (m_mode == 1 && m_t == 3) ok = 1; else step();
        end
        chk("t1_reach", ok, 1);
        rst = 1; repeat (3) step(); rst = 0; step();
        chk("t1_en", tx_en, 0); chk("t1_lvl", fifo_level, 0);
        chk("t1_cnt", frame_cnt, 0); chk("t1_rdy", s_ready, 1);

        // Single byte 0xC3, done on the 5th wait cycle, then the gap
        s_valid = 1; s_data = 8'hC3; step(); s_valid = 0;
        stream = '0; nbits = 0; ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (m_mode == 1 && m_t == NB + 4) ok = 1;
            else begin
                step();
                if (tx_en && nbits < NB) begin stream = {stream[14:0], tx_bit}; nbits++; end
            end
        end
        chk("t2_reach", ok, 1);
        exp_stream = (NB == 16) ? 16'hA5C3 : 16'h00C3;
        chk("t2_stream", stream, exp_stream);
        tx_done = 1; step(); tx_done = 0;
        chk("t2_cnt", frame_cnt, 1);
        gapn = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (!tx_en && busy) gapn++;
        end
        chk("t2_gap", gapn, GAP);

        // Six bytes host-held against a stalled FSM
        k = 0; maxl = 0; saw_full = 0;
        for (int i = 0; i < 300 && k < 6; i++) begin
            s_valid = 1; s_data = 8'h10 + 8'(k);
            step();
            if (m_acc) k++;
            if (!s_ready) saw_full = 1;
            if (int'(fifo_level) > maxl) maxl = int'(fifo_level);
        end
        s_valid = 0;
        chk("t3_acc", k, 6); chk("t3_full", saw_full, 1); chk("t3_maxlvl", maxl, DEPTH);

        // Timeout, clear, clear colliding with a new timeout
        chk("t4_err", timeout_err, 1); chk("t4_cnt", frame_cnt, 1);
        err_clr = 1; step(); err_clr = 0;
        chk("t4_clr", timeout_err, 0);
        ok = 0;
        for (int i = 0; i < 300 && !ok; i++) if (at_expiry()) ok = 1; else step();
        chk("t4_reach", ok, 1);
        err_clr = 1; step(); err_clr = 0;
        chk("t4_setwins", timeout_err, 1);
        err_clr = 1; step(); err_clr = 0;

        // Done on the expiry cycle; done outside the wait is ignored
        ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            if (at_expiry()) ok = 1;
            else begin tx_done = !(m_mode == 1 && m_t >= NB); step(); end
        end
        chk("t5_reach", ok, 1);
        tx_done = 1; step(); tx_done = 0;
        chk("t5_cnt", frame_cnt, 2); chk("t5_err", timeout_err, 0);

        tx_done = 1;
        for (int i = 0; i < 600 && !(m_mode == 0 && m_q.size() == 0); i++) step();
        tx_done = 0;
        chk("t5_drain", m_mode == 0 && m_q.size() == 0, 1);

        // Counter wrap
        force dut.r_frame_cnt = 16'hFFFF;
        #1 release dut.r_frame_cnt;
        m_cnt = 16'hFFFF;
        s_valid = 1; s_data = 8'h3C; step(); s_valid = 0;
        tx_done = 1; ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin step(); if (m_cnt == 16'h0000) ok = 1; end
        tx_done = 0;
        chk("t6_wrap", frame_cnt, 16'h0000); chk("t6_reach", ok, 1);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            s_valid   = ($urandom % 3) != 0;
            s_data    = 8'($urandom);
            tx_done   = ($urandom % 12) == 0;
            err_clr   = ($urandom % 25) == 0;
            tx_active = ($urandom % 4) == 0;
            rst       = ($urandom % 900) == 0;
            step();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end
endmodule
